result_write_arbiter: RTL and testbench

RESULT_WRITE_ARBITER -- requirements
Module: result_write_arbiter

---
 rtl/result_write_arbiter_if.sv | 30 +++
 rtl/result_write_arbiter.sv | 139 +++++++++++++
 tb/tb_result_write_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/result_write_arbiter_if.sv
// rtl/result_write_arbiter_if.sv - requester and memory-write bus for the result write arbiter
interface result_write_arbiter_if;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wait_req;

  modport master (
    input  req,
    input  req_data,
    input  wait_req,
    output ack,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output req,
    output req_data,
    output wait_req,
    input  ack,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/result_write_arbiter.sv
// rtl/result_write_arbiter.sv - round-robin arbiter writing match results into a ring of memory slots
module result_write_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          NUM_SLOTS   = 5,
  parameter logic [31:0] SLOT_STRIDE = 32'd4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          en,
  input  logic                          clr,
  result_write_arbiter_if.master        bus,
  output logic [3:0]                    slot_ptr,
  output logic                          wrap,
  output logic [15:0]                   result_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);

  state_t      state_q, state_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  last_winner_q, last_winner_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  slot_q, slot_d;
  logic        wrap_q, wrap_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  pick;

  // Walk from the farthest candidate to the nearest so the nearest one after
  // last_winner overwrites the others and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(bus.req, last_winner_q);

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    wr_en_d       = wr_en_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    ack_d         = 4'b0000;
    slot_d        = slot_q;
    wrap_d        = 1'b0;
    count_d       = count_q;

    case (state_q)
      IDLE: begin
        wr_en_d = 1'b0;
        if (en && (bus.req != 4'b0000)) begin
          winner_d      = pick;
          last_winner_d = pick;
          wr_data_d     = bus.req_data[32*pick +: 32];
          wr_addr_d     = BASE_ADDR + (32'(slot_q) * SLOT_STRIDE);
          wr_en_d       = 1'b1;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        if (!bus.wait_req) begin
          wr_en_d = 1'b0;
          ack_d   = 4'b0001 << winner_q;
          if (slot_q == LAST_SLOT) begin
            slot_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            slot_d = slot_q + 4'd1;
          end
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        wr_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Clear wins over an advance on the same edge and never reports a wrap.
    if (clr) begin
      slot_d  = 4'd0;
      count_d = 16'd0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      winner_q      <= 2'd0;
      last_winner_q <= 2'd3;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 32'd0;
      wr_data_q     <= 32'd0;
      ack_q         <= 4'b0000;
      slot_q        <= 4'd0;
      wrap_q        <= 1'b0;
      count_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      ack_q         <= ack_d;
      slot_q        <= slot_d;
      wrap_q        <= wrap_d;
      count_q       <= count_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign slot_ptr     = slot_q;
  assign wrap         = wrap_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_result_write_arbiter.sv
// tb/tb_result_write_arbiter.sv - directed and randomized bench for result_write_arbiter
module tb_result_write_arbiter;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          SLOTS = 5;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en;
  logic        clr;
  logic [3:0]  slot_ptr;
  logic        wrap;
  logic [15:0] result_count;

  result_write_arbiter_if bus();

  result_write_arbiter #(
    .BASE_ADDR  (BASE),
    .NUM_SLOTS  (SLOTS),
    .SLOT_STRIDE(32'd4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .clr         (clr),
    .bus         (bus),
    .slot_ptr    (slot_ptr),
    .wrap        (wrap),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: which slot is next, how many writes landed, who won last.
  int m_slot;
  int m_count;
  int m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_slot  = 0;
    m_count = 0;
    m_last  = 3;
  endtask

  task automatic txn(input int stall, input bit drop_en, input bit do_clr,
                     output logic [3:0] got_ack, output logic [31:0] got_addr);
    int          w;
    logic [31:0] ea;
    logic [31:0] ed;
    bit          exp_wrap;
    w = model_pick(bus.req, m_last);
    check("req_nonzero", 32'(w >= 0), 32'd1);
    if (w < 0) w = 0;
    ea = BASE + 32'(m_slot) * 32'd4;
    ed = bus.req_data[w*32 +: 32];
    bus.wait_req = (stall > 0);
    @(negedge clk);
    check("grant_wr_en", 32'(bus.wr_en), 32'd1);
    check("grant_addr", bus.wr_addr, ea);
    check("grant_data", bus.wr_data, ed);
    check("grant_no_ack", 32'(bus.ack), 32'd0);
    m_last   = w;
    got_addr = bus.wr_addr;
    if (drop_en) en = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (s == 0) bus.req_data[w*32 +: 32] = ~ed;
      @(negedge clk);
      check("stall_wr_en", 32'(bus.wr_en), 32'd1);
      check("stall_addr", bus.wr_addr, ea);
      check("stall_data", bus.wr_data, ed);
      check("stall_no_ack", 32'(bus.ack), 32'd0);
    end
    bus.wait_req = 1'b0;
    clr = do_clr;
    @(negedge clk);
    if (do_clr) begin
      m_slot   = 0;
      m_count  = 0;
      exp_wrap = 1'b0;
    end else begin
      m_slot   = (m_slot + 1) % SLOTS;
      exp_wrap = (m_slot == 0);
      if (m_count < 65535) m_count++;
    end
    check("accept_ack", 32'(bus.ack), 32'(4'b0001 << w));
    check("accept_wr_en", 32'(bus.wr_en), 32'd0);
    check("accept_slot", 32'(slot_ptr), 32'(m_slot));
    check("accept_count", 32'(result_count), 32'(m_count));
    check("accept_wrap", 32'(wrap), 32'(exp_wrap));
    got_ack = bus.ack;
    bus.req = bus.req & ~bus.ack;
    clr = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    check("ack_pulse_end", 32'(bus.ack), 32'd0);
    check("wrap_pulse_end", 32'(wrap), 32'd0);
    check("post_wr_en", 32'(bus.wr_en), 32'd0);
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] ad;
    logic [3:0]  fresh;

    n_rst = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    bus.req = 4'b0000;
    bus.req_data = '0;
    bus.wait_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_slot", 32'(slot_ptr), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);

    // Single write from requester 1.
    bus.req = 4'b0010;
    bus.req_data[63:32] = 32'hDEAD_BEEF;
    txn(0, 1'b0, 1'b0, a, ad);
    check("single_ack", 32'(a), 32'h2);
    check("single_addr", ad, 32'h1000);
    check("single_slot", 32'(slot_ptr), 32'd1);
    check("single_count", 32'(result_count), 32'd1);

    // Reset in the middle of a stalled write.
    bus.req = 4'b0100;
    bus.req_data[95:64] = 32'h1234_5678;
    bus.wait_req = 1'b1;
    @(negedge clk);
    check("rstmid_wr_en_before", 32'(bus.wr_en), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("rstmid_wr_en", 32'(bus.wr_en), 32'd0);
    check("rstmid_ack", 32'(bus.ack), 32'd0);
    check("rstmid_slot", 32'(slot_ptr), 32'd0);
    check("rstmid_count", 32'(result_count), 32'd0);
    bus.req = 4'b0000;
    bus.wait_req = 1'b0;
    @(negedge clk);
    check("rstmid_no_ack", 32'(bus.ack), 32'd0);
    n_rst = 1'b1;
    model_reset();
    @(negedge clk);

    // Fairness with all four requesting: order 0,1,2,3.
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b0, 1'b0, a, ad);
      check("fair_order", 32'(a), 32'(4'b0001 << i));
      check("fair_addr", ad, 32'h1000 + 32'(4 * i));
    end

    // Two more writes: slot 4 wraps, then slot 0 again.
    bus.req = 4'b1000;
    bus.req_data[127:96] = 32'h5555_0004;
    txn(0, 1'b0, 1'b0, a, ad);
    check("wrap_addr5", ad, 32'h1010);
    check("wrap_slot5", 32'(slot_ptr), 32'd0);
    bus.req = 4'b0001;
    bus.req_data[31:0] = 32'h5555_0005;
    txn(0, 1'b0, 1'b0, a, ad);
    check("wrap_addr6", ad, 32'h1000);
    check("wrap_count6", 32'(result_count), 32'd6);

    // Four-cycle stall with en dropped during the write.
    bus.req = 4'b0100;
    bus.req_data[95:64] = 32'hCAFE_F00D;
    txn(4, 1'b1, 1'b0, a, ad);
    check("stall_ack", 32'(a), 32'h4);

    // en low blocks new grants.
    en = 1'b0;
    bus.req = 4'b0001;
    bus.req_data[31:0] = 32'h0BAD_0001;
    repeat (3) begin
      @(negedge clk);
      check("en_low_idle", 32'(bus.wr_en), 32'd0);
    end
    en = 1'b1;
    txn(0, 1'b0, 1'b0, a, ad);

    // Clear on the accept edge.
    bus.req = 4'b0010;
    bus.req_data[63:32] = 32'h7777_0001;
    txn(1, 1'b0, 1'b1, a, ad);
    check("clr_ack", 32'(a), 32'h2);
    check("clr_slot", 32'(slot_ptr), 32'd0);
    check("clr_count", 32'(result_count), 32'd0);

    // Randomized traffic; held requesters keep their data until acked.
    for (int n = 0; n < 40; n++) begin
      fresh = 4'($urandom_range(1, 15)) & ~bus.req;
      for (int i = 0; i < 4; i++)
        if (fresh[i]) bus.req_data[i*32 +: 32] = $urandom();
      bus.req = bus.req | fresh;
      txn(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), a, ad);
    end
    while (bus.req != 4'b0000) txn(0, 1'b0, 1'b0, a, ad);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
